// File: rtl/la_prog_loader.sv
// la_prog_loader
// Loads instruction words into the user core's program memory and controls the
// core reset, driven by commands from the management SoC over the logic
// analyzer bus. A command is presented on la_cmd_* and announced by flipping
// la_cmd_tgl_i; completion is signalled by la_cmd_ack_o becoming equal to it.
//
// Ports:
//   wb_clk_i       system clock
//   wb_rst_i       synchronous active-high reset
//   la_cmd_data_i  command data word
//   la_cmd_addr_i  command word address
//   la_cmd_op_i    opcode: 00 NOP, 01 WRITE, 10 RUN, 11 HALT
//   la_cmd_tgl_i   command toggle, any change marks a new command
//   la_cmd_ack_o   ack toggle, equals la_cmd_tgl_i when the command is done
//   mem_we_o       program memory write request
//   mem_addr_o     program memory write address
//   mem_wdata_o    program memory write data
//   mem_ready_i    memory accepts the write this cycle
//   core_rst_o     core reset, active-high
//   busy_o         command in progress
//   err_o          sticky: WRITE issued while the core runs
//   word_count_o   successful writes since last HALT/reset, saturating
//   checksum_o     wrapping sum of written words
module la_prog_loader #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_i,
  input  logic [DATA_W-1:0] la_cmd_data_i,
  input  logic [ADDR_W-1:0] la_cmd_addr_i,
  input  logic [1:0]        la_cmd_op_i,
  input  logic              la_cmd_tgl_i,
  output logic              la_cmd_ack_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic              mem_ready_i,
  output logic              core_rst_o,
  output logic              busy_o,
  output logic              err_o,
  output logic [ADDR_W:0]   word_count_o,
  output logic [DATA_W-1:0] checksum_o
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MEM  = 2'd1;
  localparam logic [1:0] S_ACK  = 2'd2;

  localparam logic [1:0] OP_NOP   = 2'b00;
  localparam logic [1:0] OP_WRITE = 2'b01;
  localparam logic [1:0] OP_RUN   = 2'b10;
  localparam logic [1:0] OP_HALT  = 2'b11;

  localparam logic [ADDR_W:0] CNT_MAX = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0] CNT_ONE = {{ADDR_W{1'b0}}, 1'b1};

  logic [1:0]        state_q, state_d;
  logic [1:0]        op_q, op_d;
  logic              tgl_seen_q, tgl_seen_d;
  logic              ack_q, ack_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              core_rst_q, core_rst_d;
  logic              busy_q, busy_d;
  logic              err_q, err_d;
  logic [ADDR_W:0]   cnt_q, cnt_d;
  logic [DATA_W-1:0] sum_q, sum_d;

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    tgl_seen_d = tgl_seen_q;
    ack_d      = ack_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    core_rst_d = core_rst_q;
    busy_d     = busy_q;
    err_d      = err_q;
    cnt_d      = cnt_q;
    sum_d      = sum_q;

    case (state_q)
      S_IDLE: begin
        // Toggles arriving while busy are held off until we are back here;
        // only the latest toggle level matters.
        if (la_cmd_tgl_i != tgl_seen_q) begin
          tgl_seen_d = la_cmd_tgl_i;
          busy_d     = 1'b1;
          op_d       = la_cmd_op_i;
          if (la_cmd_op_i == OP_WRITE && core_rst_q) begin
            state_d = S_MEM;
            we_d    = 1'b1;
            addr_d  = la_cmd_addr_i;
            wdata_d = la_cmd_data_i;
          end else begin
            state_d = S_ACK;
          end
        end
      end
      S_MEM: begin
        // Request is held stable until the memory takes it; no timeout.
        if (mem_ready_i) begin
          we_d    = 1'b0;
          if (cnt_q != CNT_MAX) cnt_d = cnt_q + CNT_ONE;
          sum_d   = sum_q + wdata_q;
          state_d = S_ACK;
        end
      end
      S_ACK: begin
        case (op_q)
          // A WRITE that reached ACK with the core in reset already went
          // through memory; only a WRITE while running is an error.
          OP_WRITE: if (!core_rst_q) err_d = 1'b1;
          OP_RUN:   core_rst_d = 1'b0;
          OP_HALT: begin
            core_rst_d = 1'b1;
            cnt_d      = '0;
            sum_d      = '0;
            err_d      = 1'b0;
          end
          default: ;
        endcase
        ack_d   = tgl_seen_q;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q    <= S_IDLE;
      op_q       <= OP_NOP;
      // Adopt the current toggle level so nothing is executed after reset.
      tgl_seen_q <= la_cmd_tgl_i;
      ack_q      <= la_cmd_tgl_i;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      core_rst_q <= 1'b1;
      busy_q     <= 1'b0;
      err_q      <= 1'b0;
      cnt_q      <= '0;
      sum_q      <= '0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      tgl_seen_q <= tgl_seen_d;
      ack_q      <= ack_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      core_rst_q <= core_rst_d;
      busy_q     <= busy_d;
      err_q      <= err_d;
      cnt_q      <= cnt_d;
      sum_q      <= sum_d;
    end
  end

  assign la_cmd_ack_o = ack_q;
  assign mem_we_o     = we_q;
  assign mem_addr_o   = addr_q;
  assign mem_wdata_o  = wdata_q;
  assign core_rst_o   = core_rst_q;
  assign busy_o       = busy_q;
  assign err_o        = err_q;
  assign word_count_o = cnt_q;
  assign checksum_o   = sum_q;

endmodule
